lin_interp_up8: RTL and testbench
=================================

Name: lin_interp_up8

Overview:
- Linear-interpolation upsampler directly downstream of the sum/difference scaling stage.
- Consumes the scaled 48 kHz L+R (or L-R) sample stream (18-bit signed word plus one-cycle ready strobe).
- Produces an L-times-faster interpolated stream, paced by an external output-rate tick.
- Two instances (L+R path, L-R path) feed the stereo multiplex / NCO stage.

Parameters:
- W, 18, sample width (signed, two's complement) for input and output.
- LOG2L, 3, log2 of the upsampling factor; L = 2^LOG2L (default 8: 48 kHz -> 384 kHz).
- CW, 8, width of the saturating underrun/overrun diagnostic counters.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising clock edge; reset==0 resets.
- x_in  in  W  new input sample, signed; valid only while x_rdy=1.
- x_rdy  in  1  one-cycle strobe; x_in is accepted on this cycle.
- tick  in  1  one-cycle output-rate strobe; requests one output sample.
- y_out  out  W  interpolated output sample, signed; held between strobes.
- y_vld  out  1  one-cycle pulse; y_out was updated this cycle.
- underrun_cnt  out  CW  saturating count of ticks served in HOLD.
- overrun_cnt  out  CW  saturating count of samples accepted before the segment completed.

Behaviour:
- Reset (reset==0 at clock edge):
  - y_out=0, y_vld=0, both counters=0.
  - Internal state: x_prev=0, x_curr=0, acc=0, delta=0, k=0.
  - State goes to EMPTY.
  - Reset overrides x_rdy and tick on the same edge. Reset mid-segment discards all history.
- Internal widths:
  - delta is W+1 bits: x_curr - x_prev, exact, no saturation.
  - acc is W+LOG2L+1 bits, signed.
  - k is LOG2L+1 bits, range 0..L.
- Sample load (x_rdy=1):
  - x_prev<=x_curr, x_curr<=x_in, delta<=x_in-x_curr.
  - acc<=x_curr<<<LOG2L, k<=0.
- Output step (tick=1). On the next edge:
  - y_out<=acc>>>LOG2L (arithmetic shift; truncation toward -inf); y_vld<=1.
  - If k<L: acc<=acc+delta and k<=k+1.
  - Tick-to-y_vld latency is 1 cycle.
  - Output is always between x_prev and x_curr inclusive, so no overflow. After L steps, acc equals x_curr<<<LOG2L exactly.
- States:
  - EMPTY: no sample yet.
    - tick -> y_out=0, y_vld=1, no counter update.
    - x_rdy -> load and go to RUN.
  - RUN: segment in progress.
    - tick -> output step.
    - When the step takes k from L-1 to L, go to HOLD.
    - x_rdy with k<L -> overrun_cnt+1 (saturating), load, stay in RUN.
  - HOLD: k==L.
    - tick -> y_out=x_curr, y_vld=1, underrun_cnt+1 (saturating), acc unchanged.
    - x_rdy -> load and go to RUN; no overrun.
- Simultaneous x_rdy and tick:
  - The load is applied first and the tick is served from the new segment in the same edge.
  - y_out<=old x_curr (the new x_prev).
  - acc<=(old x_curr<<<LOG2L)+(x_in-old x_curr); k<=1.
  - overrun_cnt follows the rules for the pre-load state.
  - From EMPTY: y_out<=0, state goes to RUN with k=1.
- Counters:
  - Saturate at 2^CW-1; never wrap.
  - Cleared only by reset.
- y_vld is never asserted without a tick on the previous edge. y_out holds its value otherwise.
- Nominal rate: one x_rdy per exactly L ticks gives 0 overruns and 0 underruns.

Test Plan:
- Reset held low 3 cycles with tick and x_rdy toggling -> y_out=0, y_vld=0, counters=0. First tick after release gives y_out=0, y_vld=1 one cycle later.
- Load 0 then 800, then 8 ticks -> y_out = 0, 100, 200, 300, 400, 500, 600, 700. A 9th tick gives 800 with underrun_cnt=1; a 10th gives 800 with underrun_cnt=2.
- Load -131072 then 131071, then 8 ticks -> first output -131072. Outputs are monotonic, with step 32767 or 32768 (delta 262143 needs 19 bits). The 8th output is 98303; the following HOLD tick gives 131071. No wrap anywhere.
- Load 0 then 80; x_rdy with x_in=0 coinciding with the 3rd tick -> outputs 0, 10, then 80 (old x_curr) on the simultaneous edge, then 70, 60. overrun_cnt=1.
- Regular stream, one x_rdy every 8 ticks for 64 samples of a ramp +8 per sample -> every output step is +1 and both counters stay 0.
- Force 300 HOLD ticks -> underrun_cnt saturates at 255. Reset low mid-segment -> outputs return to EMPTY behaviour (y_out=0 on the next tick).

Source files
------------

// File: rtl/lin_interp_up8_if.sv
// Sample-in / interpolated-sample-out bundle for lin_interp_up8.
// The master side drives samples and ticks. The slave side returns outputs and diagnostics.
interface lin_interp_up8_if #(
  parameter int W  = 18,
  parameter int CW = 8
);
  logic [W-1:0]  x_in;
  logic          x_rdy;
  logic          tick;
  logic [W-1:0]  y_out;
  logic          y_vld;
  logic [CW-1:0] underrun_cnt;
  logic [CW-1:0] overrun_cnt;

  modport master (
    output x_in, x_rdy, tick,
    input  y_out, y_vld, underrun_cnt, overrun_cnt
  );

  modport slave (
    input  x_in, x_rdy, tick,
    output y_out, y_vld, underrun_cnt, overrun_cnt
  );
endinterface

// File: rtl/lin_interp_up8.sv
// Linear-interpolation upsampler by L = 2^LOG2L, paced by an external output tick.
// An accumulator steps from x_prev toward x_curr in L equal increments of delta.
module lin_interp_up8 #(
  parameter int W     = 18,
  parameter int LOG2L = 3,
  parameter int CW    = 8
) (
  input logic               clock,
  input logic               reset,
  lin_interp_up8_if.slave   bus
);
  localparam int unsigned L  = 1 << LOG2L;
  localparam int          AW = W + LOG2L + 1;
  localparam int          DW = W + 1;
  localparam int          KW = LOG2L + 1;

  typedef enum logic [1:0] {S_EMPTY, S_RUN, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic signed [W-1:0]  x_prev_q, x_prev_d;
  logic signed [W-1:0]  x_curr_q, x_curr_d;
  logic signed [W-1:0]  y_q, y_d;
  logic signed [DW-1:0] delta_q, delta_d, delta_ld;
  logic signed [AW-1:0] acc_q, acc_d, acc_base;
  logic [KW-1:0]        k_q, k_d;
  logic                 vld_q, vld_d;
  logic [CW-1:0]        und_q, und_d;
  logic [CW-1:0]        ovr_q, ovr_d;

  always_comb begin
    delta_ld = DW'($signed(bus.x_in)) - DW'(x_curr_q);
    acc_base = AW'(x_curr_q) <<< LOG2L;

    state_d  = state_q;
    x_prev_d = x_prev_q;
    x_curr_d = x_curr_q;
    y_d      = y_q;
    delta_d  = delta_q;
    acc_d    = acc_q;
    k_d      = k_q;
    vld_d    = 1'b0;
    und_d    = und_q;
    ovr_d    = ovr_q;

    if (bus.x_rdy) begin
      if (state_q == S_RUN && k_q < KW'(L) && ovr_q != '1)
        ovr_d = ovr_q + 1'b1;
      x_prev_d = x_curr_q;
      x_curr_d = $signed(bus.x_in);
      delta_d  = delta_ld;
      acc_d    = acc_base;
      k_d      = '0;
      state_d  = S_RUN;
      // A coincident tick takes step 0 of the new segment: output old x_curr, advance once.
      if (bus.tick) begin
        y_d   = x_curr_q;
        vld_d = 1'b1;
        acc_d = acc_base + AW'(delta_ld);
        k_d   = KW'(1);
        if (k_d == KW'(L))
          state_d = S_HOLD;
      end
    end else if (bus.tick) begin
      vld_d = 1'b1;
      unique case (state_q)
        S_EMPTY: y_d = '0;
        S_RUN: begin
          y_d = W'(acc_q >>> LOG2L);
          if (k_q < KW'(L)) begin
            acc_d = acc_q + AW'(delta_q);
            k_d   = k_q + 1'b1;
            if (k_d == KW'(L))
              state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          y_d = x_curr_q;
          if (und_q != '1)
            und_d = und_q + 1'b1;
        end
        default: y_d = y_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_EMPTY;
      x_prev_q <= '0;
      x_curr_q <= '0;
      y_q      <= '0;
      delta_q  <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      vld_q    <= 1'b0;
      und_q    <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_prev_q <= x_prev_d;
      x_curr_q <= x_curr_d;
      y_q      <= y_d;
      delta_q  <= delta_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      vld_q    <= vld_d;
      und_q    <= und_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.y_out        = y_q;
  assign bus.y_vld        = vld_q;
  assign bus.underrun_cnt = und_q;
  assign bus.overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_lin_interp_up8.sv
// Randomized and directed bench for lin_interp_up8 against an arithmetic segment model.
module tb_lin_interp_up8;
  localparam int W     = 18;
  localparam int LOG2L = 3;
  localparam int CW    = 8;
  localparam longint L    = longint'(1) << LOG2L;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  localparam int M_EMPTY = 0;
  localparam int M_RUN   = 1;
  localparam int M_HOLD  = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  lin_interp_up8_if #(.W(W), .CW(CW)) bus ();

  lin_interp_up8 #(.W(W), .LOG2L(LOG2L), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int     m_mode;
  longint m_prev, m_curr, m_y, m_k, m_und, m_ovr;
  bit     m_vld;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0)))
      q = q - 1;
    return q;
  endfunction

  // Segment model: output j of a segment is floor(prev + j*(curr-prev)/L).
  task automatic model_edge(input bit rst_n, input bit rdy, input longint x, input bit tk);
    if (!rst_n) begin
      m_mode = M_EMPTY;
      m_prev = 0; m_curr = 0; m_y = 0; m_k = 0;
      m_und = 0; m_ovr = 0; m_vld = 0;
      return;
    end
    m_vld = 0;
    if (rdy) begin
      if (m_mode == M_RUN && m_ovr < CMAX)
        m_ovr++;
      m_prev = m_curr;
      m_curr = x;
      m_k    = 0;
      m_mode = M_RUN;
    end
    if (tk) begin
      m_vld = 1;
      case (m_mode)
        M_EMPTY: m_y = 0;
        M_RUN: begin
          m_y = floor_div(m_prev * L + m_k * (m_curr - m_prev), L);
          m_k++;
          if (m_k == L)
            m_mode = M_HOLD;
        end
        default: begin
          m_y = m_curr;
          if (m_und < CMAX)
            m_und++;
        end
      endcase
    end
  endtask

  task automatic cyc(input bit rdy, input longint x, input bit tk);
    bus.x_rdy = rdy;
    bus.x_in  = W'(x);
    bus.tick  = tk;
    @(posedge clock);
    #1;
    model_edge(reset, rdy, x, tk);
    bus.x_rdy = 1'b0;
    bus.tick  = 1'b0;
    chk("y_vld", longint'(bus.y_vld), longint'(m_vld));
    chk("y_out", longint'($signed(bus.y_out)), m_y);
    chk("underrun_cnt", longint'(bus.underrun_cnt), m_und);
    chk("overrun_cnt", longint'(bus.overrun_cnt), m_ovr);
  endtask

  function automatic longint rnd_sample();
    return longint'($urandom_range(0, (1 << W) - 1)) - (longint'(1) << (W - 1));
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++)
      cyc(bit'($urandom_range(0, 1)), rnd_sample(), bit'($urandom_range(0, 1)));
    reset = 1'b1;
  endtask

  function automatic longint yv();
    return longint'($signed(bus.y_out));
  endfunction

  initial begin
    longint last, o0, d;
    int     idx;
    bit     rdy_r, tk_r;

    bus.x_rdy = 1'b0;
    bus.x_in  = '0;
    bus.tick  = 1'b0;

    // Reset with toggling inputs, then first tick from EMPTY.
    do_reset(3);
    chk("rst_y", yv(), 0);
    chk("rst_vld", longint'(bus.y_vld), 0);
    chk("rst_und", longint'(bus.underrun_cnt), 0);
    chk("rst_ovr", longint'(bus.overrun_cnt), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("empty_tick_y", yv(), 0);
    chk("empty_tick_vld", longint'(bus.y_vld), 1);
    cyc(0, 0, 0);
    chk("vld_one_cycle", longint'(bus.y_vld), 0);

    // 0 -> 800 ramp and HOLD.
    do_reset(1);
    cyc(1, 0, 0);
    cyc(1, 800, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("ramp800", yv(), 100 * i);
    end
    cyc(0, 0, 1);
    chk("hold9_y", yv(), 800);
    chk("hold9_und", longint'(bus.underrun_cnt), 1);
    cyc(0, 0, 1);
    chk("hold10_y", yv(), 800);
    chk("hold10_und", longint'(bus.underrun_cnt), 2);

    // Full-scale swing needing the 19-bit delta.
    do_reset(1);
    cyc(1, -131072, 0);
    cyc(1, 131071, 0);
    last = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      if (i == 0) chk("big_first", yv(), -131072);
      else begin
        d = yv() - last;
        chk("big_step", longint'(d == 32767 || d == 32768), 1);
      end
      if (i == 7) chk("big_last", yv(), 98303);
      last = yv();
    end
    cyc(0, 0, 1);
    chk("big_hold", yv(), 131071);

    // Load coinciding with the 3rd tick.
    do_reset(1);
    cyc(1, 0, 0);
    cyc(1, 80, 0);
    cyc(0, 0, 1); chk("sim_t1", yv(), 0);
    cyc(0, 0, 1); chk("sim_t2", yv(), 10);
    o0 = longint'(bus.overrun_cnt);
    cyc(1, 0, 1); chk("sim_t3", yv(), 80);
    chk("sim_ovr_inc", longint'(bus.overrun_cnt) - o0, 1);
    cyc(0, 0, 1); chk("sim_t4", yv(), 70);
    cyc(0, 0, 1); chk("sim_t5", yv(), 60);

    // Nominal rate ramp: +1 per output, no diagnostics.
    do_reset(1);
    idx = 0;
    last = 0;
    for (int n = 0; n < 64; n++) begin
      cyc(1, 8 * n, 0);
      for (int t = 0; t < 8; t++) begin
        cyc(0, 0, 1);
        if (idx >= 9) chk("nominal_step", yv() - last, 1);
        last = yv();
        idx++;
      end
    end
    chk("nominal_und", longint'(bus.underrun_cnt), 0);
    chk("nominal_ovr", longint'(bus.overrun_cnt), 0);

    // Underrun saturation, then reset mid-segment.
    do_reset(1);
    cyc(1, 1234, 0);
    repeat (8) cyc(0, 0, 1);
    repeat (300) cyc(0, 0, 1);
    chk("und_sat", longint'(bus.underrun_cnt), 255);
    cyc(1, -500, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    reset = 1'b0;
    cyc(1, 777, 1);
    reset = 1'b1;
    cyc(0, 0, 1);
    chk("post_reset_y", yv(), 0);
    chk("post_reset_vld", longint'(bus.y_vld), 1);

    // Random traffic with sparse resets.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      rdy_r = ($urandom_range(0, 7) == 0);
      tk_r  = bit'($urandom_range(0, 1));
      cyc(rdy_r, rnd_sample(), tk_r);
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
